// File: rtl/mem_access_pkg.sv
// Shared widths, write-back select codes, size codes and state
// encoding for the RV32I memory stage.
package mem_access_pkg;

    localparam int FUNCT3_WIDTH   = 3;
    localparam int REG_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Write-back source select
    localparam logic PASS = 1'b0;
    localparam logic LOAD = 1'b1;

    // Access size, funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } ma_state_e;

endpackage

// File: rtl/mem_access_store_align.sv
// Byte-enable, replicated store data and alignment check for one
// data-memory access; purely combinational.
module mem_access_store_align
    import mem_access_pkg::*;
(
    input  logic [1:0]           size_i,
    input  logic [1:0]           off_i,
    input  logic [REG_WIDTH-1:0] rs2_i,
    output logic [3:0]           be_o,
    output logic [REG_WIDTH-1:0] wdata_o,
    output logic                 misalign_o
);

    // Decode size into lane mask, replicated data and alignment fault
    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{rs2_i[7:0]}};
            end
            SZ_H: begin
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{rs2_i[15:0]}};
                misalign_o = off_i[0];
            end
            SZ_W: begin
                be_o       = 4'b1111;
                wdata_o    = rs2_i;
                misalign_o = |off_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: issues load/store on the data port with a
// req/ack handshake, stalls execute while busy, retires to write-back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic                      ex_load,
    input  logic                      ex_store,
    input  logic [FUNCT3_WIDTH-1:0]   ex_funct3,
    input  logic [REG_WIDTH-1:0]      ex_addr,
    input  logic [REG_WIDTH-1:0]      ex_store_data,
    input  logic [REG_WIDTH-1:0]      ex_data_rd,
    input  logic [REG_ADDR_WIDTH-1:0] ex_addr_rd,
    input  logic                      ex_gpr_we,
    output logic                      stall,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [REG_WIDTH-1:0]      dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [REG_WIDTH-1:0]      dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [REG_WIDTH-1:0]      dmem_rdata,
    output logic [FUNCT3_WIDTH-1:0]   funct3_mem_wb,
    output logic                      mem_mem_wb,
    output logic                      gpr_en_mem,
    output logic                      gpr_we_mem,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd_mem,
    output logic [REG_WIDTH-1:0]      data_rd_mem,
    output logic [REG_WIDTH-1:0]      data_rd_mem_load,
    output logic                      misalign,
    output logic                      bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    ma_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [REG_WIDTH-1:0]      addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [REG_WIDTH-1:0]      wdata_q, wdata_d;
    logic                      load_q, load_d;
    logic [1:0]                off_q, off_d;
    logic [FUNCT3_WIDTH-1:0]   f3_q, f3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      gwe_q, gwe_d;
    logic [REG_WIDTH-1:0]      alu_q, alu_d;
    logic [FUNCT3_WIDTH-1:0]   wb_f3_q, wb_f3_d;
    logic                      wb_sel_q, wb_sel_d;
    logic                      wb_en_q, wb_en_d;
    logic                      wb_we_q, wb_we_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [REG_WIDTH-1:0]      wb_data_q, wb_data_d;
    logic [REG_WIDTH-1:0]      wb_load_q, wb_load_d;
    logic                      mis_q, mis_d;
    logic                      berr_q, berr_d;

    logic [3:0]           sa_be;
    logic [REG_WIDTH-1:0] sa_wdata;
    logic                 sa_mis;
    logic                 is_mem;

    assign is_mem = ex_load | ex_store;

    mem_access_store_align u_align (
        .size_i     (ex_funct3[1:0]),
        .off_i      (ex_addr[1:0]),
        .rs2_i      (ex_store_data),
        .be_o       (sa_be),
        .wdata_o    (sa_wdata),
        .misalign_o (sa_mis)
    );

    // State, bus request and write-back registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MA_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            load_q    <= 1'b0;
            off_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            gwe_q     <= 1'b0;
            alu_q     <= '0;
            wb_f3_q   <= '0;
            wb_sel_q  <= PASS;
            wb_en_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_load_q <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            gwe_q     <= gwe_d;
            alu_q     <= alu_d;
            wb_f3_q   <= wb_f3_d;
            wb_sel_q  <= wb_sel_d;
            wb_en_q   <= wb_en_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_load_q <= wb_load_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    // Next state: accept ops in IDLE, wait for ack or timeout in BUSY
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        off_d     = off_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        gwe_d     = gwe_q;
        alu_d     = alu_q;
        wb_f3_d   = wb_f3_q;
        wb_sel_d  = wb_sel_q;
        wb_en_d   = 1'b0;
        wb_we_d   = wb_we_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_load_d = wb_load_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        unique case (state_q)
            MA_IDLE: begin
                if (ex_valid && (!is_mem || sa_mis)) begin
                    wb_en_d   = 1'b1;
                    wb_sel_d  = PASS;
                    wb_f3_d   = ex_funct3;
                    wb_rd_d   = ex_addr_rd;
                    wb_data_d = ex_data_rd;
                    wb_we_d   = ex_gpr_we & ~is_mem;
                    mis_d     = is_mem;
                end else if (ex_valid) begin
                    state_d = MA_BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = ex_store & ~ex_load;
                    addr_d  = {ex_addr[REG_WIDTH-1:2], 2'b00};
                    be_d    = sa_be;
                    wdata_d = sa_wdata;
                    load_d  = ex_load;
                    off_d   = ex_addr[1:0];
                    f3_d    = ex_funct3;
                    rd_d    = ex_addr_rd;
                    gwe_d   = ex_gpr_we;
                    alu_d   = ex_data_rd;
                end
            end
            MA_BUSY: begin
                if (dmem_ack || (TIMEOUT != 0 && cnt_q == CNT_LAST)) begin
                    state_d   = MA_IDLE;
                    req_d     = 1'b0;
                    wb_en_d   = 1'b1;
                    wb_f3_d   = f3_q;
                    wb_rd_d   = rd_q;
                    wb_data_d = alu_q;
                    wb_sel_d  = PASS;
                    wb_we_d   = 1'b0;
                    if (!dmem_ack) begin
                        berr_d = 1'b1;
                    end else if (load_q) begin
                        wb_sel_d  = LOAD;
                        wb_we_d   = gwe_q;
                        wb_load_d = dmem_rdata >> {off_q, 3'b000};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    assign stall            = (state_q == MA_BUSY);
    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign funct3_mem_wb    = wb_f3_q;
    assign mem_mem_wb       = wb_sel_q;
    assign gpr_en_mem       = wb_en_q;
    assign gpr_we_mem       = wb_we_q;
    assign addr_rd_mem      = wb_rd_q;
    assign data_rd_mem      = wb_data_q;
    assign data_rd_mem_load = wb_load_q;
    assign misalign         = mis_q;
    assign bus_err          = berr_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the RV32I pipeline, between execute and write-back. Accepts one op per cycle from execute and performs load/store transactions on the data-memory port with a req/ack handshake, stalling upstream while a transaction is outstanding. Generates byte enables and replicated store data, and returns load data right-justified by byte offset. Raw, unextended load data goes to write-back, which owns sign/zero extension.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for dmem_ack before aborting with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents an op this cycle
- ex_load  in  1  op is a load
- ex_store  in  1  op is a store
- ex_funct3  in  `FUNCT3_WIDTH  access size and sign, as in the RV32I encoding
- ex_addr  in  `REG_WIDTH  effective address (ALU result)
- ex_store_data  in  `REG_WIDTH  rs2 value
- ex_data_rd  in  `REG_WIDTH  ALU result, passed through for non-load ops
- ex_addr_rd  in  `REG_ADDR_WIDTH  destination register
- ex_gpr_we  in  1  op writes rd
- stall  out  1  execute must hold its op; combinational, equals (state==BUSY)
- dmem_req  out  1  request; held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  `REG_WIDTH  {ex_addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  `REG_WIDTH  replicated store data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  `REG_WIDTH  read word; valid when dmem_ack is high
- funct3_mem_wb  out  `FUNCT3_WIDTH  registered funct3 to write-back
- mem_mem_wb  out  1  `load / `pass select to write-back
- gpr_en_mem  out  1  one-cycle retire pulse
- gpr_we_mem  out  1  rd write enable; 0 on any fault
- addr_rd_mem  out  `REG_ADDR_WIDTH  destination register
- data_rd_mem  out  `REG_WIDTH  pass-through result
- data_rd_mem_load  out  `REG_WIDTH  dmem_rdata >> (8*addr[1:0]), zero-filled
- misalign  out  1  one-cycle pulse: misaligned or illegal-size access
- bus_err  out  1  one-cycle pulse: ack timeout

## Operation
- States: IDLE and BUSY. Reset value: IDLE.
- On reset, every output and internal register is 0; dmem_req drops asynchronously.
- **IDLE, ex_valid, neither load nor store:**
  - At the next edge, register the WB fields, set mem_mem_wb=`pass, and pulse gpr_en_mem.
  - State stays IDLE.
- **IDLE, ex_valid, load or store, aligned:**
  - At the next edge, latch the address, be, wdata, op and rd fields.
  - Set dmem_req=1 and go to BUSY.
- **Alignment rule on funct3[1:0]:**
  - 00 (byte): any offset is aligned.
  - 01 (half): aligned only if addr[0]=0.
  - 10 (word): aligned only if addr[1:0]=0.
  - 11: illegal.
- **Misaligned or illegal access:**
  - No request is issued.
  - At the next edge, pulse gpr_en_mem with gpr_we_mem=0 and pulse misalign.
  - State stays IDLE.
- **Store data and byte enables** (off = addr[1:0]):
  - Byte: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - Half: be = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
  - Word: be = 4'b1111, wdata = rs2.
  - For loads, be holds the same mask and dmem_we=0.
- **BUSY:**
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable.
  - ex_valid is ignored, because stall is high.
  - A wait counter increments each cycle.
- **BUSY, dmem_ack sampled high:**
  - At that edge, drop dmem_req and pulse gpr_en_mem.
  - Load: data_rd_mem_load <= dmem_rdata >> (8*off), mem_mem_wb=`load.
  - Store: gpr_we_mem=0, mem_mem_wb=`pass.
  - Return to IDLE.
- **Timeout** (TIMEOUT≠0 and the counter reaches TIMEOUT without ack):
  - Drop dmem_req and pulse bus_err.
  - Pulse gpr_en_mem with gpr_we_mem=0.
  - Return to IDLE.
- An ack arriving while in IDLE is ignored.
- Asserting rst_n low during BUSY aborts the transaction. No retire pulse is produced.

## Timing
- Non-memory op: WB outputs valid 1 cycle after acceptance.
- Memory op:
  - dmem_req rises 1 cycle after acceptance.
  - Minimum latency from acceptance to retire is 2 cycles (ack in the first request cycle).
  - Latency is 1 + (number of request cycles up to and including ack).
- stall is high for exactly the BUSY cycles.
- Execute may present a new op in the cycle after the retire edge.
- Back-to-back non-memory ops sustain 1 op/cycle.
- WB fields hold their values between retire pulses.
- gpr_en_mem is high for exactly one cycle per accepted op.

## Structure
- Shared `defines.v`:
  - Add MA_IDLE/MA_BUSY state codes.
  - Add size codes SZ_B/SZ_H/SZ_W, reusing FUNCT3_WIDTH, REG_WIDTH, REG_ADDR_WIDTH, `pass and `load.
- Sub-module store_align: purely combinational (funct3, addr[1:0], rs2) -> (be, wdata, misalign).
- The FSM, the timeout counter and the WB registers live in mem_access.

## Test plan
- **ALU op:** ex_data_rd=0x1234, rd=5.
  - Expect gpr_en_mem pulse 1 cycle later, data_rd_mem=0x1234, mem_mem_wb=`pass, stall never high.
- **Store byte:** SB, addr=0x103, rs2=0xAABBCCDD.
  - Expect dmem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD, dmem_we=1.
  - With ack after 3 cycles: stall high 3 cycles, gpr_we_mem=0.
- **Load half:** LH, addr=0x202, rdata=0x8001_7F00 on the first request cycle.
  - Expect data_rd_mem_load=0x00008001, funct3_mem_wb=3'b001, retire 2 cycles after acceptance.
- **Misaligned:** LW at addr=0x301.
  - Expect no dmem_req, misalign pulse, gpr_en_mem pulse with gpr_we_mem=0.
- **Timeout:** TIMEOUT=4, no ack.
  - Expect dmem_req high exactly 4 cycles, then bus_err pulse, return to IDLE, stall low.
- **Reset mid-op:** rst_n low during BUSY.
  - Expect dmem_req low immediately and all outputs 0.
  - After release, an ALU op retires normally.
